pipeline_stage_reg: RTL
=======================

# pipeline_stage_reg

- Parametrised elastic pipeline stage for the RV32IM pipeline: a successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque DATA_WIDTH-bit payload with a valid/ready handshake, a global BUSYWAIT stall, a hazard-unit FLUSH and a programmable bubble/reset payload.
- An optional skid entry decouples IN_READY from OUT_READY.
- Stage-specific modules wrap it by concatenating their fields into IN_DATA/OUT_DATA.

## Interface
- DATA_WIDTH, 32: payload width in bits, ≥1.
- RESET_DATA, {DATA_WIDTH{1'b0}}: payload loaded on reset and on flush (bubble value; e.g. PC field = -4).
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  reset; synchronous, active-low.
- BUSYWAIT  input  1  global stall; while 1, no state changes except by RESET/FLUSH.
- FLUSH  input  1  synchronous invalidate of all held entries.
- IN_VALID  input  1  upstream payload valid.
- IN_READY  output  1  stage can accept this cycle.
- IN_DATA  input  DATA_WIDTH  upstream payload.
- OUT_VALID  output  1  OUT_DATA holds a live entry.
- OUT_READY  input  1  downstream accepts this cycle.
- OUT_DATA  output  DATA_WIDTH  head-entry payload, registered.
- OCCUPANCY  output  2  live entries held (0..1, or 0..2 with skid).

## Operation
- Accept: IN_VALID & IN_READY & ~BUSYWAIT. Drain: OUT_VALID & OUT_READY & ~BUSYWAIT.
- Priority per edge: RESET (low) > FLUSH > BUSYWAIT > handshake.
- RESET low: OUT_VALID=0, OUT_DATA=RESET_DATA, skid emptied (SKID_DATA=RESET_DATA), OCCUPANCY=0.
- FLUSH high (RESET high): same result as reset, regardless of BUSYWAIT, IN_VALID and OUT_READY. Any entry offered that cycle is dropped.
- BUSYWAIT high (no flush): all registers hold. IN_READY=0. A drain is not counted even if OUT_READY=1.
- Main register, no skid present:
  - accept → OUT_DATA<=IN_DATA, OUT_VALID<=1.
  - drain without accept → OUT_VALID<=0, OUT_DATA holds its last value.
  - accept and drain in the same cycle → new entry replaces the old one.
- Entries are never duplicated, reordered or lost except by FLUSH/RESET.
- OCCUPANCY = OUT_VALID + SKID_VALID (skid term 0 when compiled out).

## Timing
- Latency: IN_DATA accepted at edge N appears on OUT_DATA/OUT_VALID after edge N. One cycle when the stage is empty or draining.
- Throughput: one entry per cycle when OUT_READY=1 and BUSYWAIT=0.
- OUT_DATA, OUT_VALID and OCCUPANCY are purely registered, with no combinational path from any input.
- IN_READY without skid: ~BUSYWAIT & (~OUT_VALID | OUT_READY). This is a combinational path from OUT_READY.
- IN_READY with skid: ~BUSYWAIT & ~SKID_VALID. There is no path from OUT_READY.
- Sampling rules:
  - IN_VALID may assert while IN_READY=0; the entry is simply not taken.
  - Upstream must hold IN_DATA stable until the entry is accepted.
- Mid-operation reset or flush takes effect at that edge. On the next cycle IN_READY=~BUSYWAIT.

## Configuration
- Macro PIPE_STAGE_SKID_EN.
- Defined: adds one skid entry (SKID_DATA, SKID_VALID). Transitions, applied only when not reset, not flushed and BUSYWAIT=0:
  - accept, main full, no drain → entry goes to skid.
  - drain with skid full → skid moves to main, skid empties. A simultaneous accept is impossible because IN_READY=0.
  - accept with main empty, or accept while draining with skid empty → entry goes to main.
  - OCCUPANCY can reach 2.
- Undefined:
  - single-entry stage, no skid storage.
  - IN_READY formula without skid.
  - OCCUPANCY never exceeds 1.

## Test plan
- Reset:
  - Stimulus: DATA_WIDTH=32, RESET_DATA=32'hFFFF_FFFC. Hold RESET=0 for 1 edge with IN_VALID=1, IN_DATA=32'd23.
  - Required: OUT_VALID=0, OUT_DATA=32'hFFFF_FFFC, OCCUPANCY=0.
- Pass-through:
  - Stimulus: OUT_READY=1. Feed 10, 20, 30 on consecutive edges.
  - Required: OUT_DATA shows 10, 20, 30 one edge later each, with OUT_VALID=1 throughout.
  - Required: one edge after IN_VALID drops, OUT_VALID=0 and OUT_DATA=30.
- BUSYWAIT hold:
  - Stimulus: with OUT_DATA=32'd20 valid, set BUSYWAIT=1, IN_DATA=32'd70, IN_VALID=1 for 3 edges.
  - Required: OUT_DATA=20, OUT_VALID=1, IN_READY=0 throughout.
  - Required: on release, 70 appears after the next edge.
- Backpressure (no skid):
  - Stimulus: OUT_READY=0, feed 40 then 50.
  - Required: OUT_DATA=40, IN_READY=0, and 50 is not taken.
  - Required: raising OUT_READY passes 50 at the next edge.
- Skid (PIPE_STAGE_SKID_EN):
  - Stimulus: OUT_READY=0, feed 1, 2, 3.
  - Required: OCCUPANCY reaches 2 and IN_READY=0, so 3 is held off.
  - Required: then OUT_READY=1 drains in order 1, 2, 3, with no loss or duplication.
- Flush under stall:
  - Stimulus: OCCUPANCY=2 (skid build), BUSYWAIT=1, FLUSH=1 for one edge.
  - Required: OCCUPANCY=0, OUT_VALID=0, OUT_DATA=RESET_DATA.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// Elastic pipeline stage: valid/ready payload register with stall, flush and bubble payload.
// Optional skid entry decoupling IN_READY from OUT_READY when PIPE_STAGE_SKID_EN is defined.
module pipeline_stage_reg #(
   parameter int unsigned              DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]    RESET_DATA = {DATA_WIDTH{1'b0}}
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  BUSYWAIT,
   input  logic                  FLUSH,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [DATA_WIDTH-1:0] OUT_DATA,
   output logic [1:0]            OCCUPANCY
);

   logic                  out_valid_q, out_valid_nxt;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_nxt;
   logic [1:0]            occ_q,       occ_nxt;
   logic                  accept, drain;

`ifdef PIPE_STAGE_SKID_EN
   logic                  skid_valid_q, skid_valid_nxt;
   logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_nxt;

   // A full skid is the only thing that blocks upstream; no path from OUT_READY.
   assign IN_READY = ~BUSYWAIT & ~skid_valid_q;
`else
   assign IN_READY = ~BUSYWAIT & (~out_valid_q | OUT_READY);
`endif

   assign accept = IN_VALID & IN_READY;
   assign drain  = out_valid_q & OUT_READY & ~BUSYWAIT;

   // Next-state for the handshake path; reset/flush override in the register block.
   always_comb begin
      out_valid_nxt = out_valid_q;
      out_data_nxt  = out_data_q;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_nxt = skid_valid_q;
      skid_data_nxt  = skid_data_q;
      if (drain) begin
         if (skid_valid_q) begin
            out_data_nxt   = skid_data_q;
            skid_valid_nxt = 1'b0;
         end else if (accept) begin
            out_data_nxt = IN_DATA;
         end else begin
            out_valid_nxt = 1'b0;
         end
      end else if (accept) begin
         if (out_valid_q) begin
            skid_data_nxt  = IN_DATA;
            skid_valid_nxt = 1'b1;
         end else begin
            out_data_nxt  = IN_DATA;
            out_valid_nxt = 1'b1;
         end
      end
      occ_nxt = 2'(out_valid_nxt) + 2'(skid_valid_nxt);
`else
      if (accept) begin
         out_data_nxt  = IN_DATA;
         out_valid_nxt = 1'b1;
      end else if (drain) begin
         out_valid_nxt = 1'b0;
      end
      occ_nxt = 2'(out_valid_nxt);
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RESET || FLUSH) begin
         out_valid_q <= 1'b0;
         out_data_q  <= RESET_DATA;
         occ_q       <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
         skid_valid_q <= 1'b0;
         skid_data_q  <= RESET_DATA;
`endif
      end else begin
         out_valid_q <= out_valid_nxt;
         out_data_q  <= out_data_nxt;
         occ_q       <= occ_nxt;
`ifdef PIPE_STAGE_SKID_EN
         skid_valid_q <= skid_valid_nxt;
         skid_data_q  <= skid_data_nxt;
`endif
      end
   end

   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign OCCUPANCY = occ_q;

endmodule
